sram_frame_reader: RTL

//  Read-side client for the SRAM arbiter's spare R1 port. It is the consumer of frames

---
 rtl/sram_frame_reader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sram_frame_reader.sv
// Streams one frame of packed 8-bit pixels (4 per 32-bit word) out of SRAM through the
// arbiter's R1 read port, with credit-limited reads in flight and a ready/valid pixel output.
module sram_frame_reader #(
  parameter int unsigned N_PIXEL     = 480000,
  parameter logic [17:0] FRAME0_BASE = 18'h00000,
  parameter logic [17:0] FRAME1_BASE = 18'h20000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_sel_i,
  input  logic        start_i,
  output logic        start_ack_o,
  output logic        done_o,
  input  logic        done_ack_i,
  output logic [17:0] addr_o,
  output logic        addr_valid_o,
  input  logic        addr_ready_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [7:0]  pixel_o,
  output logic        pixel_valid_o,
  input  logic        pixel_ready_i
);

  localparam int unsigned NWORDS = N_PIXEL / 4;
  localparam int unsigned CW     = $clog2(NWORDS + 1);
  localparam int unsigned EW     = $clog2(N_PIXEL + 1);
  localparam int unsigned OW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] NWordsC  = CW'(NWORDS);
  localparam logic [EW-1:0] LastPixC = EW'(N_PIXEL - 1);
  localparam logic [OW-1:0] DepthC   = OW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [17:0]   base_q, base_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] received_q, received_d;
  logic [EW-1:0] emitted_q, emitted_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    pixel_q, pixel_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic          start_ack_q, start_ack_d;
  logic          data_ready_q;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic        busy, issue, push, consume, pop;
  logic [31:0] head_word, next_word;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
    logic [7:0] b;
    unique case (s)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign busy         = (state_q == StFetch) || (state_q == StDrain);
  // Outstanding count covers issued-but-unpopped words, so each accepted read owns a FIFO slot.
  assign addr_valid_o = (state_q == StFetch) && (issued_q < NWordsC) && (outst_q < DepthC);
  assign issue        = addr_valid_o && addr_ready_i;
  assign push         = data_valid_i && busy && (received_q < NWordsC);
  assign consume      = pixel_valid_q && pixel_ready_i;
  assign pop          = consume && (sel_q == 2'd3);
  assign head_word    = mem_q[rd_ptr_q];
  assign next_word    = mem_q[rd_ptr_q + PW'(1)];

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    issued_d      = issued_q;
    received_d    = received_q;
    emitted_d     = emitted_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    sel_d         = sel_q;
    pixel_d       = pixel_q;
    pixel_valid_d = pixel_valid_q;
    start_ack_d   = 1'b0;

    if (issue) issued_d = issued_q + CW'(1);
    if (push) begin
      received_d = received_q + CW'(1);
      wr_ptr_d   = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d   = cnt_q + OW'(push) - OW'(pop);
    outst_d = outst_q + OW'(issue) - OW'(pop);

    // The output register always mirrors head[sel]; crossing a word boundary reads the
    // following FIFO entry directly so consecutive words stream without a bubble.
    if (consume) begin
      emitted_d = emitted_q + EW'(1);
      if (sel_q == 2'd3) begin
        sel_d         = 2'd0;
        pixel_valid_d = (cnt_q > OW'(1));
        if (cnt_q > OW'(1)) pixel_d = next_word[7:0];
      end else begin
        sel_d   = sel_q + 2'd1;
        pixel_d = byte_of(head_word, sel_q + 2'd1);
      end
    end else if (!pixel_valid_q && (cnt_q != '0)) begin
      pixel_d       = byte_of(head_word, sel_q);
      pixel_valid_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d       = StFetch;
          start_ack_d   = 1'b1;
          base_d        = frame_sel_i ? FRAME1_BASE : FRAME0_BASE;
          issued_d      = '0;
          received_d    = '0;
          emitted_d     = '0;
          outst_d       = '0;
          cnt_d         = '0;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          sel_d         = 2'd0;
          pixel_valid_d = 1'b0;
        end
      end
      StFetch: if (issued_d == NWordsC) state_d = StDrain;
      StDrain: if (consume && (emitted_q == LastPixC)) state_d = StDone;
      default: if (done_ack_i) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      base_q        <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      emitted_q     <= '0;
      outst_q       <= '0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sel_q         <= 2'd0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      start_ack_q   <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      emitted_q     <= emitted_d;
      outst_q       <= outst_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sel_q         <= sel_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      start_ack_q   <= start_ack_d;
      data_ready_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign start_ack_o   = start_ack_q;
  assign done_o        = (state_q == StDone);
  assign addr_o        = (state_q == StFetch) ? base_q + 18'(issued_q) : '0;
  assign data_ready_o  = data_ready_q;
  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pixel_valid_q;

endmodule
